// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, optional writeback bypass and a
// per-register pending-write scoreboard used by decode to stall on RAW hazards.
module regfile_scoreboard #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned NRPORTS = 2,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned MAXPEND = 3,
  localparam int unsigned RW = $clog2(NREGS),
  localparam int unsigned CW = $clog2(MAXPEND + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NRPORTS*RW-1:0]     rs_i,
  output logic [NRPORTS*DWIDTH-1:0] rsdata_o,
  output logic [NRPORTS-1:0]        rsbusy_o,
  input  logic                      issue_valid_i,
  input  logic [RW-1:0]             issue_rd_i,
  output logic                      issue_ready_o,
  input  logic                      regwren_i,
  input  logic [RW-1:0]             rd_i,
  input  logic [DWIDTH-1:0]         datawb_i,
  output logic                      underflow_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAXPEND);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [DWIDTH-1:0] regs_d [NREGS];
  logic [CW-1:0]     cnt_q  [NREGS];
  logic [CW-1:0]     cnt_d  [NREGS];
  logic              underflow_q;
  logic              underflow_d;

  logic              wb_valid;
  logic [NREGS-1:0]  inc_v;
  logic [NREGS-1:0]  dec_v;

  assign wb_valid = regwren_i && (rd_i != '0);

  // A full destination only stalls issue if the same register is not retiring now.
  assign issue_ready_o = !(issue_valid_i && (issue_rd_i != '0) &&
                           (cnt_q[issue_rd_i] == MAX_CNT) &&
                           !(regwren_i && (rd_i == issue_rd_i)));

  for (genvar k = 0; k < NRPORTS; k++) begin : g_rport
    logic [RW-1:0] addr;
    logic          hit;

    assign addr = rs_i[k*RW +: RW];
    assign hit  = (BYPASS != 0) && regwren_i && (rd_i == addr);

    assign rsdata_o[k*DWIDTH +: DWIDTH] = (addr == '0) ? '0 :
                                          hit          ? datawb_i :
                                                         regs_q[addr];
    // The last outstanding write is satisfied when it is being forwarded now.
    assign rsbusy_o[k] = (addr != '0) && (cnt_q[addr] != '0) &&
                         !(hit && (cnt_q[addr] == ONE_CNT));
  end

  assign inc_v[0] = 1'b0;
  assign dec_v[0] = 1'b0;
  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    assign inc_v[r] = issue_valid_i && issue_ready_o && (issue_rd_i == RW'(r));
    assign dec_v[r] = regwren_i && (rd_i == RW'(r)) && (cnt_q[r] != '0);
  end

  // NOTE: every variable gets its hold value first, so no path through this
  // block leaves one unassigned and no latch is inferred.
  always_comb begin
    regs_d      = regs_q;
    cnt_d       = cnt_q;
    underflow_d = underflow_q;

    if (wb_valid) begin
      regs_d[rd_i] = datawb_i;
      if (cnt_q[rd_i] == '0) underflow_d = 1'b1;
    end

    for (int r = 1; r < NREGS; r++) begin
      if (inc_v[r] && !dec_v[r]) begin
        cnt_d[r] = cnt_q[r] + ONE_CNT;
      end else if (dec_v[r] && !inc_v[r]) begin
        cnt_d[r] = cnt_q[r] - ONE_CNT;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage array is reset on purpose: a reset must leave every
      // architectural register reading zero with no residue of earlier data.
      regs_q      <= '{default: '0};
      cnt_q       <= '{default: '0};
      underflow_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
    end
  end

  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a bypassing and a non-bypassing instance share
// stimulus and are compared every cycle against an array/counter model.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int RW = 5;
  localparam int MP = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP*RW-1:0] rs_i;
  logic            issue_valid_i;
  logic [RW-1:0]   issue_rd_i;
  logic            regwren_i;
  logic [RW-1:0]   rd_i;
  logic [DW-1:0]   datawb_i;

  logic [NP*DW-1:0] rsdata_b1, rsdata_b0;
  logic [NP-1:0]    rsbusy_b1, rsbusy_b0;
  logic             ready_b1, ready_b0;
  logic             under_b1, under_b0;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] mreg [NR];
  int            mcnt [NR];
  bit            munder;
  bit            exp_ready;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DWIDTH(DW), .NREGS(NR), .NRPORTS(NP), .BYPASS(1), .MAXPEND(MP)) u_dut_b1 (
    .clk(clk), .rst(rst), .rs_i(rs_i), .rsdata_o(rsdata_b1), .rsbusy_o(rsbusy_b1),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_ready_o(ready_b1),
    .regwren_i(regwren_i), .rd_i(rd_i), .datawb_i(datawb_i), .underflow_o(under_b1));

  regfile_scoreboard #(.DWIDTH(DW), .NREGS(NR), .NRPORTS(NP), .BYPASS(0), .MAXPEND(MP)) u_dut_b0 (
    .clk(clk), .rst(rst), .rs_i(rs_i), .rsdata_o(rsdata_b0), .rsbusy_o(rsbusy_b0),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_ready_o(ready_b0),
    .regwren_i(regwren_i), .rd_i(rd_i), .datawb_i(datawb_i), .underflow_o(under_b0));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input bit bp, input int a);
    if (a == 0) return '0;
    if (bp && regwren_i && int'(rd_i) == a) return datawb_i;
    return mreg[a];
  endfunction

  function automatic bit exp_busy(input bit bp, input int a);
    if (a == 0 || mcnt[a] == 0) return 1'b0;
    if (bp && regwren_i && int'(rd_i) == a && mcnt[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  // Compares every DUT output against the model for the currently driven inputs.
  task automatic compare_all();
    logic [NP*DW-1:0] ed1, ed0;
    logic [NP-1:0]    eb1, eb0;
    int a;
    for (int k = 0; k < NP; k++) begin
      a = int'(rs_i[k*RW +: RW]);
      ed1[k*DW +: DW] = exp_data(1'b1, a);
      ed0[k*DW +: DW] = exp_data(1'b0, a);
      eb1[k] = exp_busy(1'b1, a);
      eb0[k] = exp_busy(1'b0, a);
    end
    exp_ready = !(issue_valid_i && issue_rd_i != 0 && mcnt[issue_rd_i] == MP &&
                  !(regwren_i && rd_i == issue_rd_i));
    check("b1.rsdata", 64'(rsdata_b1), 64'(ed1));
    check("b0.rsdata", 64'(rsdata_b0), 64'(ed0));
    check("b1.rsbusy", 64'(rsbusy_b1), 64'(eb1));
    check("b0.rsbusy", 64'(rsbusy_b0), 64'(eb0));
    check("b1.issue_ready", 64'(ready_b1), 64'(exp_ready));
    check("b0.issue_ready", 64'(ready_b0), 64'(exp_ready));
    check("b1.underflow", 64'(under_b1), 64'(munder));
    check("b0.underflow", 64'(under_b0), 64'(munder));
  endtask

  task automatic model_update();
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        mreg[r] = '0;
        mcnt[r] = 0;
      end
      munder = 1'b0;
    end else begin
      if (regwren_i && rd_i != 0) begin
        if (mcnt[rd_i] == 0) munder = 1'b1;
        else mcnt[rd_i] = mcnt[rd_i] - 1;
        mreg[rd_i] = datawb_i;
      end
      if (issue_valid_i && exp_ready && issue_rd_i != 0) mcnt[issue_rd_i] = mcnt[issue_rd_i] + 1;
    end
  endtask

  // Drive one cycle's inputs after the falling edge, let them settle, compare.
  task automatic set_in(input bit r, input int a0, input int a1, input bit iv, input int ird,
                        input bit wr, input int rd, input logic [DW-1:0] d);
    rst           = r;
    rs_i          = {RW'(a1), RW'(a0)};
    issue_valid_i = iv;
    issue_rd_i    = RW'(ird);
    regwren_i     = wr;
    rd_i          = RW'(rd);
    datawb_i      = d;
    #1;
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle(input int a0, input int a1);
    set_in(0, a0, a1, 0, 0, 0, 0, '0);
  endtask

  initial begin
    for (int r = 0; r < NR; r++) begin
      mreg[r] = '0;
      mcnt[r] = 0;
    end
    munder = 1'b0;
    rst = 1'b1; rs_i = '0; issue_valid_i = 1'b0; issue_rd_i = '0;
    regwren_i = 1'b0; rd_i = '0; datawb_i = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state at several addresses.
    idle(0, 31);
    check("lit.reset.rsdata", 64'(rsdata_b1), 64'h0);
    check("lit.reset.rsbusy", 64'(rsbusy_b1), 64'h0);
    check("lit.reset.ready", 64'(ready_b1), 64'h1);
    check("lit.reset.underflow", 64'(under_b1), 64'h0);
    tick();
    idle(5, 17);
    tick();

    // Issue r5, then read it busy, then write back with bypass.
    set_in(0, 0, 0, 1, 5, 0, 0, '0);
    tick();
    idle(5, 5);
    check("lit.r5.busy", 64'(rsbusy_b1), 64'h3);
    tick();
    set_in(0, 5, 5, 0, 0, 1, 5, 32'hDEADBEEF);
    check("lit.r5.bypass.data", 64'(rsdata_b1), 64'hDEADBEEF_DEADBEEF);
    check("lit.r5.bypass.busy", 64'(rsbusy_b1), 64'h0);
    check("lit.r5.nobypass.data", 64'(rsdata_b0), 64'h0);
    check("lit.r5.nobypass.busy", 64'(rsbusy_b0), 64'h3);
    tick();
    idle(5, 5);
    check("lit.r5.stored", 64'(rsdata_b0), 64'hDEADBEEF_DEADBEEF);
    check("lit.r5.idle.busy", 64'(rsbusy_b0), 64'h0);
    tick();

    // Fill r7 to MAXPEND, then overflow attempts with and without same-cycle retire.
    for (int i = 0; i < MP; i++) begin
      set_in(0, 7, 0, 1, 7, 0, 0, '0);
      check("lit.r7.fill.ready", 64'(ready_b1), 64'h1);
      tick();
    end
    set_in(0, 7, 0, 1, 7, 0, 0, '0);
    check("lit.r7.full.ready", 64'(ready_b1), 64'h0);
    tick();
    set_in(0, 7, 0, 1, 7, 1, 7, 32'h0000_0070);
    check("lit.r7.retire.ready", 64'(ready_b1), 64'h1);
    tick();
    set_in(0, 7, 0, 1, 7, 0, 0, '0);
    check("lit.r7.still_full", 64'(ready_b1), 64'h0);
    tick();
    for (int i = 0; i < MP; i++) begin
      set_in(0, 7, 7, 0, 0, 1, 7, 32'h0000_0071 + i);
      tick();
    end
    idle(7, 0);
    check("lit.r7.drained.busy", 64'(rsbusy_b1), 64'h0);
    check("lit.r7.no_underflow", 64'(under_b1), 64'h0);
    tick();

    // Register 0 ignores writes and issues.
    set_in(0, 0, 0, 1, 0, 1, 0, 32'h12345678);
    check("lit.r0.data", 64'(rsdata_b1), 64'h0);
    check("lit.r0.ready", 64'(ready_b1), 64'h1);
    tick();
    idle(0, 0);
    check("lit.r0.underflow", 64'(under_b1), 64'h0);
    tick();

    // Unmatched writeback to r9 sets sticky underflow; reset clears it and r9.
    set_in(0, 9, 0, 0, 0, 1, 9, 32'hA5A5_0009);
    tick();
    idle(9, 0);
    check("lit.r9.underflow", 64'(under_b1), 64'h1);
    check("lit.r9.data", 64'(rsdata_b0[31:0]), 64'hA5A5_0009);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(9, 1);
      tick();
    end
    set_in(1, 9, 0, 0, 0, 0, 0, '0);
    tick();
    idle(9, 0);
    check("lit.r9.after_rst.underflow", 64'(under_b1), 64'h0);
    check("lit.r9.after_rst.data", 64'(rsdata_b1), 64'h0);
    tick();

    // Reset mid-flight discards pending counts.
    set_in(0, 0, 0, 1, 3, 0, 0, '0);
    tick();
    set_in(0, 3, 0, 1, 3, 0, 0, '0);
    tick();
    set_in(1, 3, 0, 0, 0, 0, 0, '0);
    tick();
    idle(3, 3);
    check("lit.r3.after_rst.busy", 64'(rsbusy_b1), 64'h0);
    check("lit.r3.after_rst.data", 64'(rsdata_b1), 64'h0);
    tick();
    set_in(0, 3, 0, 0, 0, 1, 3, 32'h3333_3333);
    tick();
    idle(3, 0);
    check("lit.r3.underflow", 64'(under_b1), 64'h1);
    tick();

    // Randomized traffic, concentrated on a few registers to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR-1)) : int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)),
             $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
             $urandom_range(0, 2) != 0, int'($urandom_range(0, 7)),
             DW'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
